// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the issue stage, the iterative divider and the writeback consumer.
interface div_issue_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_op;
   logic [DATA_W-1:0] in_src1;
   logic [DATA_W-1:0] in_src2;
   logic [TAG_W-1:0]  in_dest;
   logic              div_en;
   logic [1:0]        div_op;
   logic [DATA_W-1:0] div_src1;
   logic [DATA_W-1:0] div_src2;
   logic              div_busy;
   logic              div_done;
   logic [DATA_W-1:0] div_result;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [TAG_W-1:0]  out_dest;

   modport slave (
      input  in_valid, in_op, in_src1, in_src2, in_dest,
      input  div_busy, div_done, div_result, out_ready,
      output in_ready, div_en, div_op, div_src1, div_src2,
      output out_valid, out_result, out_dest
   );

   modport master (
      output in_valid, in_op, in_src1, in_src2, in_dest,
      output div_busy, div_done, div_result, out_ready,
      input  in_ready, div_en, div_op, div_src1, div_src2,
      input  out_valid, out_result, out_dest
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue controller for a multi-cycle divider: accepts one op, handles the
// divide-by-zero and signed-overflow cases locally, and survives flushes mid-flight.
module div_issue_ctrl #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   output logic            busy,
   div_issue_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

   localparam logic [DATA_W-1:0]        ALL_ONES = '1;
   localparam logic signed [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] NEG_ONE  = '1;

   state_t            state;
   logic [1:0]        op_q;
   logic [DATA_W-1:0] src1_q;
   logic [DATA_W-1:0] src2_q;
   logic [TAG_W-1:0]  dest_q;
   logic [DATA_W-1:0] result_q;
   logic              div_en_q;
   logic              out_valid_q;

   logic signed [DATA_W-1:0] dividend_s;
   logic signed [DATA_W-1:0] divisor_s;
   logic                     div_by_zero;
   logic                     signed_ovf;
   logic                     accept;

   // Results the divider is never asked for: x/0 and INT_MIN/-1 (signed only).
   function automatic logic [DATA_W-1:0] bypass_result(input logic [1:0]        op,
                                                       input logic [DATA_W-1:0] src1,
                                                       input logic              zero_div);
      if (zero_div)
         return op[0] ? src1 : ALL_ONES;
      return op[0] ? '0 : INT_MIN;
   endfunction

   assign dividend_s  = bus.in_src1;
   assign divisor_s   = bus.in_src2;
   assign div_by_zero = (bus.in_src2 == '0);
   assign signed_ovf  = !bus.in_op[1] && (dividend_s == INT_MIN) && (divisor_s == NEG_ONE);

   assign bus.in_ready = (state == IDLE) && !flush;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         op_q        <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         dest_q      <= '0;
         result_q    <= '0;
         div_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q   <= bus.in_op;
                  src1_q <= bus.in_src1;
                  src2_q <= bus.in_src2;
                  dest_q <= bus.in_dest;
                  if (div_by_zero || signed_ovf) begin
                     result_q    <= bypass_result(bus.in_op, bus.in_src1, div_by_zero);
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end else begin
                     div_en_q <= 1'b1;
                     state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (flush) begin
                  div_en_q <= 1'b0;
                  state    <= IDLE;
               end else if (bus.div_busy) begin
                  div_en_q <= 1'b0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               // A flush coinciding with completion has nothing left to drain.
               if (flush) begin
                  state <= bus.div_done ? IDLE : DRAIN;
               end else if (bus.div_done) begin
                  result_q    <= bus.div_result;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (flush || bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            DRAIN: begin
               if (bus.div_done)
                  state <= IDLE;
            end
            default: begin
               div_en_q    <= 1'b0;
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.div_en     = div_en_q;
   assign bus.div_op     = op_q;
   assign bus.div_src1   = src1_q;
   assign bus.div_src2   = src2_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = result_q;
   assign bus.out_dest   = dest_q;
   assign busy           = (state != IDLE);
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the bench itself plays the divider and the consumer.
module tb_div_issue_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic flush;
   logic busy;
   int   n_checks = 0;
   int   n_fail   = 0;

   div_issue_ctrl_if #(.DATA_W(32), .TAG_W(5)) bus ();

   div_issue_ctrl #(.DATA_W(32), .TAG_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid   = 1'b0;
      bus.in_op      = 2'b00;
      bus.in_src1    = '0;
      bus.in_src2    = '0;
      bus.in_dest    = '0;
      bus.div_busy   = 1'b0;
      bus.div_done   = 1'b0;
      bus.div_result = '0;
      bus.out_ready  = 1'b0;
      flush          = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic send_op(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [4:0] dest);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_src1  = s1;
      bus.in_src2  = s2;
      bus.in_dest  = dest;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.div_en !== 1'b0) begin n_fail++; $display("FAIL rst_div_en: got %b want 0", bus.div_en); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      n_checks++; if (bus.out_result !== 32'h0) begin n_fail++; $display("FAIL rst_out_result: got %h want 0", bus.out_result); end
      n_checks++; if (bus.out_dest !== 5'd0) begin n_fail++; $display("FAIL rst_out_dest: got %h want 0", bus.out_dest); end
      n_checks++; if ({bus.div_op, bus.div_src1, bus.div_src2} !== 66'h0) begin n_fail++; $display("FAIL rst_div_regs: got %h/%h/%h want 0", bus.div_op, bus.div_src1, bus.div_src2); end
   endtask

   task automatic test_signed_quot();
      send_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);
      n_checks++; if (bus.div_en !== 1'b1) begin n_fail++; $display("FAIL sq_div_en: got %b want 1", bus.div_en); end
      n_checks++; if (bus.div_src1 !== 32'hFFFF_FFF9 || bus.div_src2 !== 32'd2 || bus.div_op !== 2'b00) begin n_fail++; $display("FAIL sq_div_operands: got %h/%h/%h want 0/fffffff9/2", bus.div_op, bus.div_src1, bus.div_src2); end
      n_checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL sq_busy: got ready=%b busy=%b want 0/1", bus.in_ready, busy); end
      bus.div_busy = 1'b1;
      tick();
      n_checks++; if (bus.div_en !== 1'b0) begin n_fail++; $display("FAIL sq_div_en_wait: got %b want 0", bus.div_en); end
      bus.div_done   = 1'b1;
      bus.div_result = 32'hFFFF_FFFD;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sq_early_valid: got %b want 0", bus.out_valid); end
      tick();
      bus.div_done = 1'b0;
      bus.div_busy = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sq_valid: got %b want 1", bus.out_valid); end
      n_checks++; if (bus.out_result !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sq_result: got %h want fffffffd", bus.out_result); end
      n_checks++; if (bus.out_dest !== 5'd5) begin n_fail++; $display("FAIL sq_dest: got %h want 5", bus.out_dest); end
      consume();
      n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sq_idle: got valid=%b busy=%b want 0/0", bus.out_valid, busy); end
   endtask

   task automatic test_unsigned_rem_backpressure();
      send_op(2'b11, 32'd100, 32'd7, 5'd9);
      bus.div_busy = 1'b1;
      tick();
      bus.div_done   = 1'b1;
      bus.div_result = 32'd2;
      tick();
      bus.div_done = 1'b0;
      bus.div_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2 || bus.out_dest !== 5'd9) begin n_fail++; $display("FAIL ur_hold[%0d]: got valid=%b result=%h dest=%h want 1/2/9", i, bus.out_valid, bus.out_result, bus.out_dest); end
         tick();
      end
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2) begin n_fail++; $display("FAIL ur_hold_last: got valid=%b result=%h want 1/2", bus.out_valid, bus.out_result); end
      consume();
      n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ur_idle: got valid=%b busy=%b want 0/0", bus.out_valid, busy); end
   endtask

   task automatic test_div_zero();
      send_op(2'b00, 32'd5, 32'd0, 5'd3);
      n_checks++; if (bus.div_en !== 1'b0) begin n_fail++; $display("FAIL dz_quot_div_en: got %b want 0", bus.div_en); end
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_quot: got valid=%b result=%h want 1/ffffffff", bus.out_valid, bus.out_result); end
      consume();
      send_op(2'b01, 32'd5, 32'd0, 5'd4);
      n_checks++; if (bus.div_en !== 1'b0) begin n_fail++; $display("FAIL dz_rem_div_en: got %b want 0", bus.div_en); end
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd5 || bus.out_dest !== 5'd4) begin n_fail++; $display("FAIL dz_rem: got valid=%b result=%h dest=%h want 1/5/4", bus.out_valid, bus.out_result, bus.out_dest); end
      consume();
      send_op(2'b10, 32'h0000_00AB, 32'd0, 5'd1);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF || bus.div_en !== 1'b0) begin n_fail++; $display("FAIL dz_uquot: got valid=%b result=%h en=%b want 1/ffffffff/0", bus.out_valid, bus.out_result, bus.div_en); end
      consume();
   endtask

   task automatic test_overflow();
      send_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
      n_checks++; if (bus.div_en !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_quot: got en=%b valid=%b result=%h want 0/1/80000000", bus.div_en, bus.out_valid, bus.out_result); end
      consume();
      send_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
      n_checks++; if (bus.div_en !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h0) begin n_fail++; $display("FAIL ovf_rem: got en=%b valid=%b result=%h want 0/1/0", bus.div_en, bus.out_valid, bus.out_result); end
      consume();
      send_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
      n_checks++; if (bus.div_en !== 1'b1 || bus.out_valid !== 1'b0 || bus.div_op !== 2'b10) begin n_fail++; $display("FAIL ovf_unsigned_issue: got en=%b valid=%b op=%b want 1/0/10", bus.div_en, bus.out_valid, bus.div_op); end
      bus.div_busy = 1'b1;
      tick();
      bus.div_done   = 1'b1;
      bus.div_result = 32'h0;
      tick();
      bus.div_done = 1'b0;
      bus.div_busy = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0 || bus.out_dest !== 5'd8) begin n_fail++; $display("FAIL ovf_unsigned_result: got valid=%b result=%h dest=%h want 1/0/8", bus.out_valid, bus.out_result, bus.out_dest); end
      consume();
   endtask

   task automatic test_flush_drain();
      send_op(2'b10, 32'd20, 32'd4, 5'd2);
      bus.div_busy = 1'b1;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drain: got busy=%b valid=%b want 1/0", busy, bus.out_valid); end
      bus.in_valid = 1'b1;
      bus.in_op    = 2'b10;
      bus.in_src1  = 32'd9;
      bus.in_src2  = 32'd3;
      bus.in_dest  = 5'd11;
      flush        = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL fl_drain_hold: got ready=%b busy=%b want 0/1", bus.in_ready, busy); end
      bus.div_done   = 1'b1;
      bus.div_result = 32'd5;
      tick();
      bus.div_done = 1'b0;
      bus.div_busy = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_discard: got valid=%b busy=%b ready=%b want 0/0/1", bus.out_valid, busy, bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.div_en !== 1'b1 || bus.div_src1 !== 32'd9 || bus.div_src2 !== 32'd3) begin n_fail++; $display("FAIL fl_next_issue: got en=%b src=%h/%h want 1/9/3", bus.div_en, bus.div_src1, bus.div_src2); end
      bus.div_busy = 1'b1;
      tick();
      bus.div_done   = 1'b1;
      bus.div_result = 32'd3;
      tick();
      bus.div_done = 1'b0;
      bus.div_busy = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd3 || bus.out_dest !== 5'd11) begin n_fail++; $display("FAIL fl_next_result: got valid=%b result=%h dest=%h want 1/3/b", bus.out_valid, bus.out_result, bus.out_dest); end
      consume();
   endtask

   task automatic test_flush_corners();
      bus.in_valid = 1'b1;
      bus.in_op    = 2'b00;
      bus.in_src1  = 32'd6;
      bus.in_src2  = 32'd0;
      flush        = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fc_ready_flush: got %b want 0", bus.in_ready); end
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      n_checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fc_no_accept: got busy=%b valid=%b want 0/0", busy, bus.out_valid); end
      send_op(2'b01, 32'd17, 32'd5, 5'd6);
      bus.div_busy = 1'b1;
      tick();
      bus.div_done   = 1'b1;
      bus.div_result = 32'd2;
      flush          = 1'b1;
      tick();
      flush        = 1'b0;
      bus.div_done = 1'b0;
      bus.div_busy = 1'b0;
      n_checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fc_flush_done: got busy=%b valid=%b want 0/0", busy, bus.out_valid); end
      send_op(2'b00, 32'd1, 32'd0, 5'd6);
      bus.div_done = 1'b1;
      flush        = 1'b1;
      tick();
      flush        = 1'b0;
      bus.div_done = 1'b0;
      n_checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fc_flush_in_done: got busy=%b valid=%b want 0/0", busy, bus.out_valid); end
      send_op(2'b10, 32'd8, 32'd2, 5'd6);
      bus.div_done   = 1'b1;
      bus.div_result = 32'hDEAD_BEEF;
      tick();
      bus.div_done = 1'b0;
      n_checks++; if (bus.div_en !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL fc_done_in_issue: got en=%b valid=%b busy=%b want 1/0/1", bus.div_en, bus.out_valid, busy); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++; if (busy !== 1'b0 || bus.div_en !== 1'b0) begin n_fail++; $display("FAIL fc_flush_issue: got busy=%b en=%b want 0/0", busy, bus.div_en); end
   endtask

   task automatic test_stall_reset();
      send_op(2'b01, 32'h0000_1234, 32'h0000_0010, 5'd12);
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (bus.div_en !== 1'b1 || bus.div_op !== 2'b01 || bus.div_src1 !== 32'h1234 || bus.div_src2 !== 32'h10) begin n_fail++; $display("FAIL st_stall[%0d]: got en=%b op=%b src=%h/%h want 1/01/1234/10", i, bus.div_en, bus.div_op, bus.div_src1, bus.div_src2); end
         tick();
      end
      bus.div_busy = 1'b1;
      tick();
      n_checks++; if (bus.div_en !== 1'b0 || busy !== 1'b1 || bus.div_src1 !== 32'h1234) begin n_fail++; $display("FAIL st_wait: got en=%b busy=%b src1=%h want 0/1/1234", bus.div_en, busy, bus.div_src1); end
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      bus.div_busy = 1'b0;
      n_checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.div_en !== 1'b0 || bus.div_src1 !== 32'h0) begin n_fail++; $display("FAIL st_reset: got busy=%b valid=%b en=%b src1=%h want 0/0/0/0", busy, bus.out_valid, bus.div_en, bus.div_src1); end
      bus.div_done   = 1'b1;
      bus.div_result = 32'h55;
      tick();
      bus.div_done = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL st_done_idle: got valid=%b busy=%b want 0/0", bus.out_valid, busy); end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_signed_quot();
      test_unsigned_rem_backpressure();
      test_div_zero();
      test_overflow();
      test_flush_drain();
      test_flush_corners();
      test_stall_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
